ysyx_22050133_mem_arbiter: RTL

YSYX_22050133_MEM_ARBITER -- requirements
Module: ysyx_22050133_mem_arbiter

---
 rtl/ysyx_22050133_mem_arbiter_if.sv | 40 ++++
 rtl/ysyx_22050133_mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/ysyx_22050133_mem_arbiter_if.sv
// rtl/ysyx_22050133_mem_arbiter_if.sv - fetch/load-store/memory signal bundle for the memory arbiter
interface ysyx_22050133_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // Arbiter side: serves the two requesters and drives the memory port.
    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    // Environment side: requesters plus the memory.
    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/ysyx_22050133_mem_arbiter.sv
// rtl/ysyx_22050133_mem_arbiter.sv - single-outstanding IF/LS memory arbiter, YSYX_22050133_RR_ARB_EN selects round-robin
module ysyx_22050133_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    ysyx_22050133_mem_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0] state;
    logic       owner_ls;
    logic [7:0] wait_cnt;
    logic       pick_ls;
    logic       pick_if;
    logic       timed_out;
    logic       respond;

`ifdef YSYX_22050133_RR_ARB_EN
    logic last_ls;

    // Round-robin: on a conflict the side that was not served last wins.
    always_comb begin
        pick_ls = bus.ls_req & (~bus.if_req | ~last_ls);
        pick_if = bus.if_req & ~pick_ls;
    end

    // Remember who was served last; starting at IF lets LS win the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls <= 1'b0;
        end else if (state == S_IDLE && (pick_ls || pick_if)) begin
            last_ls <= pick_ls;
        end
    end
`else
    // Fixed priority: load/store always beats instruction fetch.
    always_comb begin
        pick_ls = bus.ls_req;
        pick_if = bus.if_req & ~bus.ls_req;
    end
`endif

    // Response cycle: memory answered, or the wait budget ran out.
    always_comb begin
        timed_out = (state == S_WAIT) && (wait_cnt == TIMEOUT_CNT);
        respond   = (state == S_WAIT) && (bus.mem_rvalid || timed_out);
    end

    // Grants and responses go only to the latched owner; a real response wins over a timeout.
    always_comb begin
        bus.if_gnt    = (state == S_REQ) && bus.mem_req && bus.mem_ready && !owner_ls;
        bus.ls_gnt    = (state == S_REQ) && bus.mem_req && bus.mem_ready && owner_ls;
        bus.if_rvalid = respond && !owner_ls;
        bus.ls_rvalid = respond && owner_ls;
        bus.err       = timed_out && !bus.mem_rvalid;
        bus.rdata     = ((state == S_WAIT) && bus.mem_rvalid) ? bus.mem_rdata : 32'd0;
    end

    // Transaction FSM and the registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            owner_ls      <= 1'b0;
            wait_cnt      <= 8'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_wstrb <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_ls || pick_if) begin
                        owner_ls      <= pick_ls;
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= pick_ls ? bus.ls_addr : bus.if_addr;
                        bus.mem_we    <= pick_ls & bus.ls_we;
                        bus.mem_wdata <= pick_ls ? bus.ls_wdata : 32'd0;
                        // Strobes only mean something on a write.
                        bus.mem_wstrb <= (pick_ls && bus.ls_we) ? bus.ls_wstrb : 4'd0;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        wait_cnt    <= 8'd0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (respond) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
